load_store_unit_32: RTL and testbench
=====================================

// Module: load_store_unit_32
// PURPOSE
//  Initiator side of the data-memory interface. Accepts one load/store request at a time
//  from the execute stage: byte, halfword or word, signed or unsigned. Drives the
//  word-indexed data memory (MemRead/MemWrite/address/WriteData, combinational ReadData,
//  write on posedge clk). Sub-word stores use read-modify-write. Returns extended load data.
// PARAMETERS
//  WORD_ADDR_W  5   significant word-index bits driven on MemAddress; upper bits are 0
// PORTS
//  clk           in   1   single clock; all state changes on posedge
//  reset         in   1   asynchronous, active-high reset
//  ReqValid      in   1   request present
//  ReqReady      out  1   unit idle; request accepted at posedge when ReqValid&ReqReady
//  Store         in   1   1=store, 0=load
//  Size          in   2   00 byte, 01 half, 10 word, 11 reserved
//  Unsigned      in   1   loads: 1=zero-extend, 0=sign-extend
//  Address       in   32  byte address
//  StoreData     in   32  store value, right-justified
//  Done          out  1   one-cycle completion pulse
//  LoadData      out  32  extended load result, valid while Done; 0 otherwise
//  Error         out  1   valid while Done; 1=request rejected, no memory access made
//  MemAddress    out  32  word index = Address[WORD_ADDR_W+1:2], zero-extended
//  MemWriteData  out  32  word written to memory
//  MemWrite      out  1   memory write strobe
//  MemRead       out  1   memory read enable
//  MemReadData   in   32  combinational read data from memory
// BEHAVIOUR
//  - Request fields are latched at acceptance and ignored afterwards.
//  - FSM states: IDLE, READ, WRITE, DONE. ReqReady = (state==IDLE).
//  - IDLE->READ on load or sub-word store; IDLE->WRITE on word store;
//    IDLE->DONE with Error=1 on rejected request.
//  - READ: MemRead=1. At posedge the word is captured; load->DONE, sub-word store->WRITE.
//  - WRITE: MemWrite=1 for exactly one cycle, then DONE. Word store writes StoreData.
//    Sub-word store writes the captured word with only the target lane(s) replaced.
//  - DONE: Done=1 for one cycle, then IDLE. The next request is accepted no earlier than
//    the cycle after DONE.
//  - Latency from acceptance edge to the Done cycle:
//    load 2, word store 2, sub-word store 3, rejected 1.
//  - Lanes are little-endian. Byte lane = Address[1:0] (lane 0 = bits 7:0).
//    Half lane = Address[1] (0 = bits 15:0).
//  - Load extension: the extracted byte/half is sign- or zero-extended per Unsigned.
//    Unsigned is ignored for word loads.
//  - MemAddress, MemWriteData, MemRead and MemWrite are 0 in IDLE and DONE.
//    They are decoded from state; no glitch writes.
//  - Size=11 is always rejected (Error=1).
//  - Reset (async): state->IDLE. Done, Error, LoadData, MemRead, MemWrite, MemAddress and
//    MemWriteData go to 0 immediately. ReqReady=1 after reset.
//    Reset during READ or WRITE aborts the request; the memory word stays unmodified,
//    because the write edge never occurs in WRITE.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined:
//    - A misaligned half (Address[0]=1) or word (Address[1:0]!=0) is rejected: Error=1,
//      no MemRead/MemWrite.
//  LSU_MISALIGN_TRAP_EN undefined:
//    - Misaligned low address bits are forced to 0 (half: bit0; word: bits1:0).
//    - The request executes normally and Error is only raised for Size=11.
// TESTING
//  Preload mem[3]=32'h8899AABB, mem[0]=32'h00000011.
//  1. Load, Size=00, Unsigned=0, Address=0x0D -> Done 2 cycles after accept,
//     LoadData=0xFFFFFFAA. Same with Unsigned=1 -> 0x000000AA.
//  2. Store, Size=01, Address=0x0E, StoreData=0x00001234 -> one MemRead then exactly one
//     MemWrite of 0x1234AABB to index 3. Done at cycle 3. A follow-up word load returns
//     0x1234AABB.
//  3. Store, Size=10, Address=0x14, StoreData=0xDEADBEEF -> no MemRead, MemWrite at index 5
//     with 0xDEADBEEF, Done at cycle 2.
//  4. Load, Size=10, Address=0x02 -> with LSU_MISALIGN_TRAP_EN: Error=1, Done at cycle 1,
//     MemRead/MemWrite never asserted. Without it: LoadData=0x00000011, Error=0.
//  5. Store byte 0xFF to 0x0C; assert reset during READ -> all outputs 0 at once, ReqReady=1,
//     mem[3] still 0x8899AABB.
//  6. Hold ReqValid high with back-to-back requests -> each accepted only when ReqReady=1.
//     Done pulses are never adjacent to a new acceptance in the same cycle.

Source files
------------

// File: rtl/load_store_unit_32.sv
// Load/store unit: byte/half/word accesses to a word-indexed data memory.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned half/word requests.
module load_store_unit_32 #(
  parameter int WORD_ADDR_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        Store,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        Error,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                   store_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [WORD_ADDR_W+1:0] addr_q;
  logic [31:0]            sdata_q;
  logic [31:0]            word_q;
  logic                   err_q;

  logic        accept;
  logic        rej;
  logic [1:0]  lo_a;
  logic [31:0] wdata;
  logic [31:0] sh;
  logic [31:0] ld;
  logic        unused_addr;

  assign unused_addr = ^Address[31:WORD_ADDR_W+2];
  assign ReqReady    = (state_q == S_IDLE);
  assign accept      = ReqValid & ReqReady;

`ifdef LSU_MISALIGN_TRAP_EN
  assign rej = (Size == 2'b11)
             | ((Size == 2'b01) & Address[0])
             | ((Size == 2'b10) & (|Address[1:0]));
`else
  assign rej = (Size == 2'b11);
`endif

  // Low address bits are cleared to the natural alignment of the access.
  always_comb begin
    lo_a = Address[1:0];
    unique case (1'b1)
      (Size == 2'b01): lo_a = {Address[1], 1'b0};
      (Size == 2'b10): lo_a = 2'b00;
      default:         lo_a = Address[1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (rej)
            state_d = S_DONE;
          else if (Store && Size == 2'b10)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = store_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q <= Store;
        size_q  <= Size;
        uns_q   <= Unsigned;
        addr_q  <= {Address[WORD_ADDR_W+1:2], lo_a};
        sdata_q <= StoreData;
        err_q   <= rej;
      end
      if (state_q == S_READ)
        word_q <= MemReadData;
    end
  end

  always_comb begin
    wdata = word_q;
    unique case (1'b1)
      (size_q == 2'b00):
        wdata[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
      (size_q == 2'b01):
        wdata[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
      default:
        wdata = sdata_q;
    endcase
  end

  assign sh = word_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld = word_q;
    unique case (1'b1)
      (size_q == 2'b00): ld = {{24{~uns_q & sh[7]}}, sh[7:0]};
      (size_q == 2'b01): ld = {{16{~uns_q & sh[15]}}, sh[15:0]};
      default:           ld = word_q;
    endcase
  end

  assign MemRead  = (state_q == S_READ);
  assign MemWrite = (state_q == S_WRITE);
  assign MemAddress = (MemRead | MemWrite)
    ? {{(30-WORD_ADDR_W){1'b0}}, addr_q[WORD_ADDR_W+1:2]}
    : 32'h0;
  assign MemWriteData = MemWrite ? wdata : 32'h0;

  assign Done     = (state_q == S_DONE);
  assign Error    = Done & err_q;
  assign LoadData = (Done & ~err_q & ~store_q) ? ld : 32'h0;

endmodule

// File: tb/tb_load_store_unit_32.sv
// Directed bench for load_store_unit_32 with a 32-word memory model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_load_store_unit_32;

  logic        clk;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        Store;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Address;
  logic [31:0] StoreData;
  logic        Done;
  logic [31:0] LoadData;
  logic        Error;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  logic [31:0] mem [0:31];

  int nvec;
  int nmis;
  int rd_cnt;
  int wr_cnt;
  logic [31:0] wa;
  logic [31:0] wd;

  load_store_unit_32 #(.WORD_ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .Store        (Store),
    .Size         (Size),
    .Unsigned     (Unsigned),
    .Address      (Address),
    .StoreData    (StoreData),
    .Done         (Done),
    .LoadData     (LoadData),
    .Error        (Error),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign MemReadData = mem[MemAddress[4:0]];

  always @(posedge clk)
    if (MemWrite) mem[MemAddress[4:0]] <= MemWriteData;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE and observe until Done (bounded).
  task automatic run(input logic st, input logic [1:0] sz,
                     input logic un, input logic [31:0] a,
                     input logic [31:0] sd, output int lat,
                     output logic [31:0] ld, output logic er);
    rd_cnt = 0;
    wr_cnt = 0;
    wa = '0;
    wd = '0;
    lat = -1;
    ld = '0;
    er = 1'b0;
    ReqValid = 1'b1;
    Store = st;
    Size = sz;
    Unsigned = un;
    Address = a;
    StoreData = sd;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    Size = 2'b11;
    Address = ~a;
    StoreData = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (MemRead) rd_cnt++;
      if (MemWrite) begin
        wr_cnt++;
        wa = MemAddress;
        wd = MemWriteData;
      end
      if (Done) begin
        lat = c;
        ld = LoadData;
        er = Error;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int lat;
  logic [31:0] ld;
  logic er;
  int acc, dn, ovl;

  initial begin
    nvec = 0;
    nmis = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h8899AABB;
    mem[0] = 32'h00000011;
    reset = 1'b1;
    ReqValid = 1'b0;
    Store = 1'b0;
    Size = 2'b00;
    Unsigned = 1'b0;
    Address = 32'h0;
    StoreData = 32'h0;
    #2;
    check("rst_ready", {31'h0, ReqReady}, 32'h1);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_ld", LoadData, 32'h0);
    check("rst_mem", {MemAddress[29:0], MemRead, MemWrite}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: byte loads, lane 1 of 0x8899AABB
    run(1'b0, 2'b00, 1'b0, 32'h0D, 32'h0, lat, ld, er);
    check("lb_lat", lat, 32'd2);
    check("lb_data", ld, 32'hFFFFFFAA);
    check("lb_err", {31'h0, er}, 32'h0);
    run(1'b0, 2'b00, 1'b1, 32'h0D, 32'h0, lat, ld, er);
    check("lbu_data", ld, 32'h000000AA);

    // signed half, lane 0
    run(1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, lat, ld, er);
    check("lh_data", ld, 32'hFFFFAABB);

    // 2: half store read-modify-write
    run(1'b1, 2'b01, 1'b0, 32'h0E, 32'h00001234, lat, ld, er);
    check("sh_lat", lat, 32'd3);
    check("sh_rd", rd_cnt, 32'd1);
    check("sh_wr", wr_cnt, 32'd1);
    check("sh_wa", wa, 32'd3);
    check("sh_wd", wd, 32'h1234AABB);
    check("sh_ld0", ld, 32'h0);
    run(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, ld, er);
    check("lw_after", ld, 32'h1234AABB);
    run(1'b0, 2'b00, 1'b1, 32'h0F, 32'h0, lat, ld, er);
    check("lbu_lane3", ld, 32'h00000012);

    // 3: word store
    run(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, lat, ld, er);
    check("sw_lat", lat, 32'd2);
    check("sw_rd", rd_cnt, 32'd0);
    check("sw_wr", wr_cnt, 32'd1);
    check("sw_wa", wa, 32'd5);
    check("sw_wd", wd, 32'hDEADBEEF);
    check("sw_mem", mem[5], 32'hDEADBEEF);

    // 4: misaligned word load
    run(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, lat, ld, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_lat", lat, 32'd1);
    check("mis_err", {31'h0, er}, 32'h1);
    check("mis_rd", rd_cnt, 32'd0);
    check("mis_wr", wr_cnt, 32'd0);
`else
    check("mis_lat", lat, 32'd2);
    check("mis_err", {31'h0, er}, 32'h0);
    check("mis_data", ld, 32'h00000011);
`endif

    // reserved size
    run(1'b1, 2'b11, 1'b0, 32'h0C, 32'hFFFFFFFF, lat, ld, er);
    check("rsv_lat", lat, 32'd1);
    check("rsv_err", {31'h0, er}, 32'h1);
    check("rsv_acc", rd_cnt + wr_cnt, 32'd0);

    // 5: reset during READ of a byte store
    mem[3] = 32'h8899AABB;
    ReqValid = 1'b1;
    Store = 1'b1;
    Size = 2'b00;
    Unsigned = 1'b0;
    Address = 32'h0C;
    StoreData = 32'hFF;
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
    @(negedge clk);
    check("ab_rd", {31'h0, MemRead}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ab_mem", {MemAddress[29:0], MemRead, MemWrite}, 32'h0);
    check("ab_wd", MemWriteData, 32'h0);
    check("ab_done", {30'h0, Done, Error}, 32'h0);
    check("ab_ready", {31'h0, ReqReady}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ab_word", mem[3], 32'h8899AABB);

    // 6: back-to-back with ReqValid held high
    acc = 0;
    dn = 0;
    ovl = 0;
    ReqValid = 1'b1;
    Store = 1'b0;
    Size = 2'b10;
    Address = 32'h0C;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ReqValid && ReqReady) acc++;
      if (Done) begin
        dn++;
        check("b2b_data", LoadData, 32'h8899AABB);
      end
      if (Done && ReqReady) ovl++;
    end
    ReqValid = 1'b0;
    check("b2b_acc", acc, 32'd4);
    check("b2b_done", dn, 32'd4);
    check("b2b_ovl", ovl, 32'd0);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
